// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell, LSB first, WIDTH edges per operation.
// Optional SERIAL_ADDER_SUB_EN adds a sub port for A-B (cout=1 means no borrow).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout, r_busy, r_done;
    logic             w_s, w_c, w_last, w_sub;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last = r_cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= RUN;
                    r_a     <= a;
                    r_b     <= w_sub ? ~b : b;
                    r_carry <= w_sub | cin;
                    r_cnt   <= '0;
                    r_sum   <= '0;
                    r_cout  <= 1'b0;
                    r_busy  <= 1'b1;
                end
                RUN: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    // counter parks on WIDTH-1 so it never wraps
                    if (w_last) begin
                        r_state <= DONE;
                        r_cout  <= w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=8 and WIDTH=2 instances).
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start2 = 1'b0, cin2 = 1'b0, busy2, done2, cout2;
    logic [1:0] a2 = '0, b2 = '0, sum2;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8 = 1'b0, sub2 = 1'b0;
`endif

    typedef struct {
        logic [32:0] r;
        int          k;
    } exp_t;

    exp_t q8[$], q2[$];
    exp_t e8, e2;
    int   bc8 = 0, bc2 = 0;
    logic [8:0] last8 = '0;
    logic [2:0] last2 = '0;

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub2),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Reference: {cout,sum} is the true (WIDTH+1)-bit sum, or for subtraction the wrapped difference with cout = no borrow
    function automatic logic [32:0] model(input int w, input int a, input int b, input int c, input logic s);
        longint r;
        r = s ? ((a >= b) ? (longint'(1) << w) : 0) + ((a - b + (1 << w)) % (1 << w))
              : longint'(a) + b + c;
        return 33'(r);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            bc8 = 0;
            last8 = '0;
        end else begin
            if (busy8) bc8++;
            if (done8) begin
                if (q8.size() == 0) chk("u8_spurious_done", done8, 0);
                else begin
                    e8 = q8.pop_front();
                    chk("u8_result", {cout8, sum8}, e8.r);
                    chk("u8_latency", cyc - e8.k, 8);
                    chk("u8_busy_cycles", bc8, 8);
                    last8 = e8.r[8:0];
                end
                bc8 = 0;
            end else if (!busy8) chk("u8_hold", {cout8, sum8}, last8);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            bc2 = 0;
            last2 = '0;
        end else begin
            if (busy2) bc2++;
            if (done2) begin
                if (q2.size() == 0) chk("u2_spurious_done", done2, 0);
                else begin
                    e2 = q2.pop_front();
                    chk("u2_result", {cout2, sum2}, e2.r);
                    chk("u2_latency", cyc - e2.k, 2);
                    chk("u2_busy_cycles", bc2, 2);
                    last2 = e2.r[2:0];
                end
                bc2 = 0;
            end else if (!busy2) chk("u2_hold", {cout2, sum2}, last2);
        end
    end

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while ((busy8 || done8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("u8_idle_timeout", n >= 40, 0);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        wait_idle8();
        a8 = a;
        b8 = b;
        cin8 = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = s;
`endif
        start8 = 1'b1;
        q8.push_back('{model(8, int'(a), int'(b), int'(c), s), cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'($urandom);
`endif
    endtask

    task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while ((busy2 || done2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("u2_idle_timeout", n >= 20, 0);
        a2 = a;
        b2 = b;
        cin2 = c;
        start2 = 1'b1;
        q2.push_back('{model(2, int'(a), int'(b), int'(c), 1'b0), cyc + 1});
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom);
        b2 = 2'($urandom);
        cin2 = 1'($urandom);
    endtask

    initial begin
        logic s;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst_u2", {busy2, done2, cout2, sum2}, 0);
        rst = 1'b0;

        issue8(8'h00, 8'h00, 1'b0, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0, 1'b0);
        issue8(8'hA5, 8'h5A, 1'b1, 1'b0);
        issue8(8'hFF, 8'hFF, 1'b1, 1'b0);

        // new operands pulsed mid-run must be ignored
        issue8(8'h3C, 8'h21, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        a8 = 8'hEE;
        b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;

        // start held high: accepted every WIDTH+2 cycles
        wait_idle8();
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
        start8 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            q8.push_back('{model(8, int'(a8), int'(b8), int'(cin8), 1'b0), cyc + 1});
            repeat (9) begin
                @(negedge clk);
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                cin8 = 1'($urandom);
            end
            if (j < 2) @(negedge clk);
            else start8 = 1'b0;
        end

        // reset in the 4th RUN cycle aborts without done
        issue8(8'h77, 8'h88, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_done", done8, 0);
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        issue8(8'h03, 8'h04, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        issue8(8'h10, 8'h01, 1'b0, 1'b1);
        issue8(8'h01, 8'h02, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 25; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            issue8(8'($urandom), 8'($urandom), 1'($urandom), s);
        end

        for (int i = 0; i < 32; i++) issue2(2'(i >> 3), 2'(i >> 1), 1'(i));

        n = 0;
        while ((q8.size() != 0 || q2.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_queues", q8.size() + q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
